// File: rtl/sseg_scan_decoder.sv
// Reads back a multiplexed active-low 7-segment scan and recovers the four BCD
// digits, with frame, blank, illegal-pattern, anode-error and stall flags.
module sseg_scan_decoder #(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [3:0]  seg_err,
    output logic        frame_valid,
    output logic        an_err,
    output logic        stalled
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    SETTLE_C  = 4'(SETTLE);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    logic [3:0]    an_r;
    logic [6:0]    sseg_r;
    logic [3:0]    settle_r;
    logic [TW-1:0] timer_r;
    logic [3:0]    seen_r;
    logic          done_r;

    logic          an_change_s;
    logic          sseg_change_s;
    logic          onehot_s;
    logic          multi_s;
    logic [1:0]    idx_s;
    logic          capture_s;
    logic [5:0]    dec_s;
    logic [3:0]    seen_next_s;
    logic [TW-1:0] timer_next_s;

    // Returns {blank, illegal, value} for an active-low segment pattern.
    function automatic logic [5:0] decode_seg(input logic [6:0] pat);
        logic [5:0] res;
        case (pat)
            7'h40:   res = {1'b0, 1'b0, 4'h0};
            7'h79:   res = {1'b0, 1'b0, 4'h1};
            7'h24:   res = {1'b0, 1'b0, 4'h2};
            7'h30:   res = {1'b0, 1'b0, 4'h3};
            7'h19:   res = {1'b0, 1'b0, 4'h4};
            7'h12:   res = {1'b0, 1'b0, 4'h5};
            7'h02:   res = {1'b0, 1'b0, 4'h6};
            7'h78:   res = {1'b0, 1'b0, 4'h7};
            7'h00:   res = {1'b0, 1'b0, 4'h8};
            7'h10:   res = {1'b0, 1'b0, 4'h9};
            7'h7F:   res = {1'b1, 1'b0, 4'hF};
            default: res = {1'b0, 1'b1, 4'hF};
        endcase
        return res;
    endfunction

    // The change terms compare the value being sampled with the stored one, so
    // counters clear on the same edge that loads a new an_r/sseg_r.
    assign an_change_s   = (an != an_r);
    assign sseg_change_s = (sseg != sseg_r);
    assign dec_s         = decode_seg(sseg_r);

    // Classify the sampled anode pattern.
    always_comb begin
        onehot_s = 1'b0;
        multi_s  = 1'b0;
        idx_s    = 2'd0;
        case (an_r)
            4'b1110: begin onehot_s = 1'b1; idx_s = 2'd0; end
            4'b1101: begin onehot_s = 1'b1; idx_s = 2'd1; end
            4'b1011: begin onehot_s = 1'b1; idx_s = 2'd2; end
            4'b0111: begin onehot_s = 1'b1; idx_s = 2'd3; end
            4'b1111: multi_s = 1'b0;
            default: multi_s = 1'b1;
        endcase
    end

    // Capture qualification, frame bookkeeping and stall-timer next value.
    always_comb begin
        capture_s   = (settle_r == SETTLE_C) && !done_r && onehot_s;
        seen_next_s = seen_r | (4'b0001 << idx_s);
        if (an_change_s) begin
            timer_next_s = {TW{1'b0}};
        end else if (timer_r != TIMEOUT_C) begin
            timer_next_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            timer_next_s = timer_r;
        end
    end

    // Input sampling, settle counter, stall timer and anode error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_r     <= 4'hF;
            sseg_r   <= 7'h7F;
            settle_r <= 4'd0;
            timer_r  <= {TW{1'b0}};
            an_err   <= 1'b0;
            stalled  <= 1'b0;
        end else begin
            an_r    <= an;
            sseg_r  <= sseg;
            timer_r <= timer_next_s;
            stalled <= (timer_next_s == TIMEOUT_C);
            an_err  <= multi_s;
            if (an_change_s || sseg_change_s) begin
                settle_r <= 4'd0;
            end else if (settle_r != SETTLE_C) begin
                settle_r <= settle_r + 4'd1;
            end else begin
                settle_r <= settle_r;
            end
        end
    end

    // Digit capture and frame-complete pulse; a new anode dwell re-arms done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits      <= 16'h0000;
            blank       <= 4'h0;
            seg_err     <= 4'h0;
            seen_r      <= 4'h0;
            done_r      <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (capture_s) begin
                digits[idx_s*4 +: 4] <= dec_s[3:0];
                blank[idx_s]         <= dec_s[5];
                seg_err[idx_s]       <= dec_s[4];
                if (seen_next_s == 4'hF) begin
                    seen_r      <= 4'h0;
                    frame_valid <= 1'b1;
                end else begin
                    seen_r <= seen_next_s;
                end
            end else begin
                seen_r <= seen_r;
            end
            if (an_change_s) begin
                done_r <= 1'b0;
            end else if (capture_s) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end
        end
    end

endmodule
